// File: rtl/sevenseg_decoder_pkg.sv
// sevenseg_pkg: shared seven-segment definitions.
//   - gfedcba pattern constants for digits 0-9 and blank (also used by the driver)
//   - code constants for blank and invalid patterns
//   - lock FSM state type
//   - seg_decode(): pattern -> {invalid, code}
package sevenseg_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] CODE_BLANK   = 4'd12;
   localparam logic [3:0] CODE_INVALID = 4'd15;

   typedef struct packed {
      logic       invalid;
      logic [3:0] code;
   } seg_code_t;

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_SETTLING,
      ST_LOCKED
   } lock_state_t;

   function automatic seg_code_t seg_decode(input logic [6:0] pat);
      seg_code_t r;
      r.invalid = 1'b0;
      case (pat)
         SEG_0:     r.code = 4'd0;
         SEG_1:     r.code = 4'd1;
         SEG_2:     r.code = 4'd2;
         SEG_3:     r.code = 4'd3;
         SEG_4:     r.code = 4'd4;
         SEG_5:     r.code = 4'd5;
         SEG_6:     r.code = 4'd6;
         SEG_7:     r.code = 4'd7;
         SEG_8:     r.code = 4'd8;
         SEG_9:     r.code = 4'd9;
         SEG_BLANK: r.code = CODE_BLANK;
         default: begin
            r.code    = CODE_INVALID;
            r.invalid = 1'b1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sevenseg_decoder_if.sv
// sevenseg_decoder_if: history FIFO read port of sevenseg_decoder.
//   rd_en     pop the FIFO head
//   rd_data   FIFO head {invalid, value}, first-word fall-through
//   empty     FIFO empty
//   full      FIFO full
//   overflow  sticky: a push was dropped
// master = consumer of the history, slave = the decoder.
interface sevenseg_decoder_if;

   logic       rd_en;
   logic [4:0] rd_data;
   logic       empty;
   logic       full;
   logic       overflow;

   modport master (output rd_en, input rd_data, empty, full, overflow);
   modport slave  (input rd_en, output rd_data, empty, full, overflow);

endinterface

// File: rtl/sevenseg_decoder_fifo.sv
// seg_history_fifo: small first-word fall-through FIFO of committed codes.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and 5-bit entry
//   rd_en        pop request (ignored while empty)
//   rd_data      head entry, 0 while empty
//   empty, full  occupancy flags
//   overflow     sticky, set when a push is dropped; cleared only by reset
// Pointers carry one extra wrap bit so full/empty need no counter.
module seg_history_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [4:0] wdata,
   input  logic       rd_en,
   output logic [4:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [4:0]  mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic        overflow_q, overflow_d;
   logic        do_push, do_pop;

   always_comb begin
      empty    = (wptr_q == rptr_q);
      full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      do_pop   = rd_en && !empty;
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      do_push  = push && (!full || do_pop);
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      overflow_d = overflow_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (push && !do_push) overflow_d = 1'b1;
      rd_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
      overflow = overflow_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: samples an asynchronous 7-bit segment bus, waits for it to
// be stable for STABLE_CYCLES synchronized samples, and decodes it to a digit code.
//   clk, rst_n    clock, asynchronous active-low reset
//   seg_in        {g,f,e,d,c,b,a}, active high, asynchronous to clk
//   value         last committed code (0-9 digit, 12 blank, 15 invalid)
//   value_valid   a pattern has been committed since reset
//   invalid       last committed pattern is not in the decode table
//   change_pulse  one-cycle strobe per commit
//   hist          history FIFO read port (sevenseg_decoder_if.slave)
// Optional history FIFO: define SEVENSEG_DECODER_HISTORY_EN. Without it the
// read port ties off to empty and rd_en is ignored.
module sevenseg_decoder
   import sevenseg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [6:0]               seg_in,
   output logic [3:0]               value,
   output logic                     value_valid,
   output logic                     invalid,
   output logic                     change_pulse,
   sevenseg_decoder_if.slave        hist
);

   localparam logic [7:0] HIT_CNT = 8'(STABLE_CYCLES - 1);

   logic [6:0]  sync1_q;
   logic [6:0]  s_q;
   logic [6:0]  s_prev_q;
   logic [7:0]  cnt_q, cnt_d;
   lock_state_t state_q, state_d;
   logic [6:0]  locked_q, locked_d;
   logic [3:0]  value_q, value_d;
   logic        invalid_q, invalid_d;
   logic        valid_q, valid_d;
   logic        pulse_q, pulse_d;
   logic        stable, hit, commit;
   seg_code_t   dec;

   always_comb begin
      stable = (s_q == s_prev_q);
      cnt_d  = '0;
      if (stable) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      // cnt still holds the old run length on the cycle s changes; the stable
      // term keeps a single new sample from committing on a stale count.
      hit    = stable && (cnt_q == HIT_CNT);
      dec    = seg_decode(s_q);

      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         ST_UNLOCKED: begin
            if (hit) begin
               commit  = 1'b1;
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (s_q != locked_q) state_d = ST_SETTLING;
         end
         ST_SETTLING: begin
            if (s_q == locked_q) begin
               state_d = ST_LOCKED;
            end else if (hit) begin
               commit  = 1'b1;
               state_d = ST_LOCKED;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase

      locked_d  = locked_q;
      value_d   = value_q;
      invalid_d = invalid_q;
      valid_d   = valid_q;
      pulse_d   = commit;
      if (commit) begin
         locked_d  = s_q;
         value_d   = dec.code;
         invalid_d = dec.invalid;
         valid_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         s_q       <= '0;
         s_prev_q  <= '0;
         cnt_q     <= '0;
         state_q   <= ST_UNLOCKED;
         locked_q  <= '0;
         value_q   <= CODE_BLANK;
         invalid_q <= 1'b0;
         valid_q   <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         sync1_q   <= seg_in;
         s_q       <= sync1_q;
         s_prev_q  <= s_q;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         locked_q  <= locked_d;
         value_q   <= value_d;
         invalid_q <= invalid_d;
         valid_q   <= valid_d;
         pulse_q   <= pulse_d;
      end
   end

   assign value        = value_q;
   assign invalid      = invalid_q;
   assign value_valid  = valid_q;
   assign change_pulse = pulse_q;

`ifdef SEVENSEG_DECODER_HISTORY_EN
   // Pushed on the commit edge itself so the entry is visible with change_pulse.
   seg_history_fifo #(
      .DEPTH (DEPTH)
   ) u_hist (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (commit),
      .wdata    (dec),
      .rd_en    (hist.rd_en),
      .rd_data  (hist.rd_data),
      .empty    (hist.empty),
      .full     (hist.full),
      .overflow (hist.overflow)
   );
`else
   localparam int unsigned HIST_DEPTH_UNUSED = DEPTH;
   logic unused_rd_en;
   assign unused_rd_en  = hist.rd_en;
   assign hist.rd_data  = '0;
   assign hist.empty    = 1'b1;
   assign hist.full     = 1'b0;
   assign hist.overflow = 1'b0;
`endif

endmodule
